// File: rtl/position_addr_gen.sv
// Multi-lane result-memory address generator: walks DEPTH entries (interleaved)
// or LANES planes of PLANE_SIZE (planar), one registered group per accepted beat.
`timescale 1ns/1ps
module position_addr_gen #(
    parameter int ADDR_W     = 10,
    parameter int LANES      = 3,
    parameter int DEPTH      = 507,
    parameter int PLANE_SIZE = 169
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    abort,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [LANES*ADDR_W-1:0] addr_o,
    output logic [LANES-1:0]        lane_en_o,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int AW1  = ADDR_W + 1;
    localparam int KW   = ADDR_W + 1;
    localparam int G_IL = (DEPTH + LANES - 1) / LANES;
    localparam logic [KW-1:0]  KLAST_IL = KW'(G_IL - 1);
    localparam logic [KW-1:0]  KLAST_PL = KW'(PLANE_SIZE - 1);
    localparam logic [AW1-1:0] DEPTH_X  = AW1'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mode;
    logic [KW-1:0]       r_k;
    logic                r_valid;
    logic                r_last;
    logic                r_done;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_addr [LANES];
    logic [LANES-1:0]    r_lane_en;

    logic                w_hs;
    logic                w_load;
    logic                w_adv;
    logic                w_fin;
    logic                w_clr;
    logic [AW1-1:0]      w_step;
    logic [AW1-1:0]      w_sum [LANES];
    logic [KW-1:0]       w_klast;
    logic [KW-1:0]       w_knext;

    // Group-0 address of a lane; constant per lane after loop unrolling.
    function automatic logic [ADDR_W-1:0] base_addr(input logic m, input int lane);
        int b;
        b = m ? lane * PLANE_SIZE : lane;
        return b[ADDR_W-1:0];
    endfunction

    assign w_hs    = r_valid & ready_i;
    assign w_step  = r_mode ? AW1'(1) : AW1'(LANES);
    assign w_klast = r_mode ? KLAST_PL : KLAST_IL;
    assign w_knext = r_k + KW'(1);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_sum[i] = {1'b0, r_addr[i]} + w_step;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_fin       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
            S_RUN: begin
                // abort wins over a handshake in the same cycle
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (w_hs) begin
                    if (r_last) begin
                        w_state_nxt = S_DONE;
                        w_fin       = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= 1'b0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_fin;
            if (w_load) begin
                r_mode  <= mode;
                r_k     <= '0;
                r_valid <= 1'b1;
                r_last  <= mode ? (KLAST_PL == '0) : (KLAST_IL == '0);
            end else if (w_adv) begin
                r_k    <= w_knext;
                r_last <= (w_knext == w_klast);
            end else if (w_fin || w_clr) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    // Per-lane address registers advance by a fixed step; masked lanes keep counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
            end
            r_lane_en <= '0;
        end else if (w_load) begin
            for (int i = 0; i < LANES; i++) begin
                r_addr[i]    <= base_addr(mode, i);
                r_lane_en[i] <= mode | (i < DEPTH);
            end
        end else if (w_adv) begin
            for (int i = 0; i < LANES; i++) begin
                r_addr[i]    <= w_sum[i][ADDR_W-1:0];
                r_lane_en[i] <= r_mode | (w_sum[i] < DEPTH_X);
            end
        end else if (w_fin || w_clr) begin
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
            end
            r_lane_en <= '0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign addr_o[g*ADDR_W +: ADDR_W] = r_addr[g];
    end

    assign valid_o   = r_valid;
    assign lane_en_o = r_lane_en;
    assign last_o    = r_last;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule
